// File: rtl/sysbus_pkg.sv
// Shared types and constants for the Sysbus arbiter: FSM states, tag field
// encodings and the default burst length.
package sysbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } sb_state_t;

  // The tag is {rw, space, id}, with rw in the MSB.
  localparam logic       READ   = 1'b0;
  localparam logic       WRITE  = 1'b1;
  localparam logic [3:0] MEMORY = 4'h0;
  localparam logic [3:0] MMIO   = 4'h1;

  localparam int SB_BEATS = 8;

  typedef struct packed {
    logic       rw;
    logic [3:0] space;
    logic [7:0] id;
  } sb_tag_t;

endpackage

// File: rtl/sysbus_arbiter_rr.sv
// Round-robin requester pick: the lowest requesting index at or after i_ptr,
// wrapping past NREQ-1. Purely combinational.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int w_cand;
    w_cand  = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!o_any && i_req[PTR_W'(w_cand)]) begin
        o_any                   = 1'b1;
        o_grant[PTR_W'(w_cand)] = 1'b1;
        o_idx                   = PTR_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus master port between NREQ requesters: round-robin grant,
// one outstanding transaction, response beats routed back to the owner only.
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = SB_BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         r_reqcyc,
  input  logic [NREQ*DATA_W-1:0]  r_req,
  input  logic [NREQ*TAG_W-1:0]   r_reqtag,
  output logic [NREQ-1:0]         r_reqack,
  output logic [NREQ-1:0]         r_respcyc,
  output logic [DATA_W-1:0]       r_resp,
  output logic [TAG_W-1:0]        r_resptag,
  input  logic [NREQ-1:0]         r_respack,
  output logic                    reqcyc,
  output logic [DATA_W-1:0]       req,
  output logic [TAG_W-1:0]        reqtag,
  input  logic                    reqack,
  input  logic                    respcyc,
  input  logic [DATA_W-1:0]       resp,
  input  logic [TAG_W-1:0]        resptag,
  output logic                    respack,
  output logic                    busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  sb_state_t         r_state;
  sb_state_t         w_state_next;
  logic [PTR_W-1:0]  r_owner;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              w_beat_inc;
  logic              r_reqcyc_q;
  logic [DATA_W-1:0] r_req_addr;
  logic [TAG_W-1:0]  r_reqtag_q;

  logic [DATA_W-1:0] w_req_arr [NREQ];
  logic [TAG_W-1:0]  w_tag_arr [NREQ];
  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_grant_idx;
  logic              w_grant_any;
  logic              w_beat_ack;
  logic              w_resp_fwd;
  logic              w_is_write;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (r_reqcyc),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  assign w_beat_ack = reqack && ((r_state == S_ADDR) || (r_state == S_WDATA));
  assign w_resp_fwd = respcyc && (r_state == S_RESP);
  assign w_is_write = (r_reqtag_q[TAG_W-1] == WRITE);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
      assign w_req_arr[gi] = r_req[gi*DATA_W +: DATA_W];
      assign w_tag_arr[gi] = r_reqtag[gi*TAG_W +: TAG_W];
      assign r_reqack[gi]  = w_beat_ack && (r_owner == PTR_W'(gi));
      assign r_respcyc[gi] = w_resp_fwd && (r_owner == PTR_W'(gi));
    end
  endgenerate

  // Write data passes straight through: the requester only advances its beat
  // after r_reqack, so a registered copy would present stale data to Sysbus.
  assign reqcyc    = r_reqcyc_q;
  assign req       = (r_state == S_WDATA) ? w_req_arr[r_owner] : r_req_addr;
  assign reqtag    = r_reqtag_q;
  assign r_resp    = resp;
  assign r_resptag = resptag;
  assign respack   = w_resp_fwd && r_respack[r_owner];
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_beat_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (reqack) w_state_next = w_is_write ? S_WDATA : S_WAIT;
      end
      S_WDATA: begin
        if (reqack) begin
          if (r_beat_cnt == LAST_BEAT) w_state_next = S_IDLE;
          else                         w_beat_inc   = 1'b1;
        end
      end
      S_WAIT: begin
        if (respcyc) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (respack) begin
          if (r_beat_cnt == LAST_BEAT) w_state_next = S_IDLE;
          else                         w_beat_inc   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_reqcyc_q <= 1'b0;
      r_req_addr <= '0;
      r_reqtag_q <= '0;
    end else begin
      r_state    <= w_state_next;
      r_reqcyc_q <= (w_state_next == S_ADDR) || (w_state_next == S_WDATA);
      if (w_state_next != r_state) r_beat_cnt <= '0;
      else if (w_beat_inc)         r_beat_cnt <= r_beat_cnt + 1'b1;
      if ((r_state == S_IDLE) && w_grant_any) begin
        r_owner    <= w_grant_idx;
        r_rr_ptr   <= (w_grant_idx == PTR_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_req_addr <= w_req_arr[w_grant_idx];
        r_reqtag_q <= w_tag_arr[w_grant_idx];
      end
    end
  end

`ifdef SYSBUS_ARB_ASSERT
  a_addr_hold: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_ADDR) |-> r_reqcyc[r_owner]);
  a_wdata_hold: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_WDATA) |-> r_reqcyc[r_owner]);
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (!reset)
    respcyc |-> ((r_state == S_WAIT) || (r_state == S_RESP)));
  a_resp_tag: assert property (@(posedge clk) disable iff (!reset)
    w_resp_fwd |-> (resptag == r_reqtag_q));
`endif

endmodule
